// File: rtl/adc_fifo_arb.sv
// Read-side scheduler for a bank of per-channel ADC FIFOs: round-robin or strict
// ascending frame order onto one channel-tagged valid/ready stream.
module adc_fifo_arb #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned DATA_WIDTH = 24,
    localparam int unsigned CH_W      = $clog2(CHANNELS)
) (
    input  logic                                clk,
    input  logic                                sclr_n,
    input  logic                                enable,
    input  logic                                mode,
    input  logic [CHANNELS-1:0]                 ch_mask,
    input  logic [CHANNELS-1:0]                 empty,
    input  logic [CHANNELS-1:0][DATA_WIDTH-1:0] q,
    output logic [CHANNELS-1:0]                 rdreq,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic [CH_W-1:0]                     out_ch,
    output logic                                out_last,
    output logic [15:0]                         frame_cnt,
    output logic                                busy
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                state_q, state_d;
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic [CHANNELS-1:0]   mask_l_q, mask_l_d;
    logic                  frame_act_q, frame_act_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  enable_q;
    logic                  mode_q;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CH_W-1:0]       out_ch_q;
    logic                  out_last_q;

    logic                  mode_eff;
    logic                  en_rise;
    logic                  free;
    logic                  load;
    logic                  rr_vld;
    logic [CH_W-1:0]       rr_g;
    logic                  wt_vld;
    logic                  cand_vld;
    logic [CH_W-1:0]       cand;
    logic                  is_last;
    logic                  rr_wrap;
    logic [CH_W-1:0]       lo_cur;
    logic [CH_W-1:0]       lo_new;
    logic [CH_W-1:0]       hi_cur;
    logic [CH_W-1:0]       nxt_cur;

    function automatic logic [CH_W-1:0] lowest_bit(input logic [CHANNELS-1:0] m);
        lowest_bit = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (m[i]) lowest_bit = CH_W'(i);
        end
    endfunction

    function automatic logic [CH_W-1:0] highest_bit(input logic [CHANNELS-1:0] m);
        highest_bit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (m[i]) highest_bit = CH_W'(i);
        end
    endfunction

    function automatic logic [CH_W-1:0] next_above(input logic [CHANNELS-1:0] m,
                                                   input logic [CH_W-1:0]     p);
        next_above = p;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (m[i] && (CH_W'(i) > p)) next_above = CH_W'(i);
        end
    endfunction

    assign lo_cur  = lowest_bit(mask_l_q);
    assign lo_new  = lowest_bit(ch_mask);
    assign hi_cur  = highest_bit(mask_l_q);
    assign nxt_cur = next_above(mask_l_q, ptr_q);

    // Mode may only switch at an idle point; mid-activity the held value is used.
    assign busy     = out_valid_q || frame_act_q;
    assign mode_eff = busy ? mode_q : mode;
    assign en_rise  = enable && !enable_q;
    assign free     = !out_valid_q || out_ready;

    // Round-robin search from ptr upward, wrapping; lowest offset wins.
    always_comb begin
        rr_vld = 1'b0;
        rr_g   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            int unsigned idx;
            idx = 32'(ptr_q) + 32'(k);
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (mask_l_q[CH_W'(idx)] && !empty[CH_W'(idx)]) begin
                rr_vld = 1'b1;
                rr_g   = CH_W'(idx);
            end
        end
    end

    assign wt_vld   = (state_q == StWait) && mask_l_q[ptr_q] && !empty[ptr_q];
    assign cand_vld = mode_eff ? wt_vld : rr_vld;
    assign cand     = mode_eff ? ptr_q : rr_g;
    assign load     = sclr_n && enable && free && cand_vld;
    assign is_last  = mode_eff && (ptr_q == hi_cur);
    assign rr_wrap  = (rr_g < ptr_q) || (rr_g == CH_W'(CHANNELS - 1));
    assign rdreq    = load ? (CHANNELS'(1) << cand) : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mask_l_d    = mask_l_q;
        frame_act_d = frame_act_q;
        frame_cnt_d = frame_cnt_q;

        if (!mode_eff) begin
            state_d     = StIdle;
            frame_act_d = 1'b0;
            if (load) begin
                ptr_d = (rr_g == CH_W'(CHANNELS - 1)) ? '0 : rr_g + CH_W'(1);
                if (rr_wrap) mask_l_d = ch_mask;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    ptr_d = lo_cur;
                    if (enable && (mask_l_q != '0)) state_d = StWait;
                end
                StWait: begin
                    if (load) begin
                        if (is_last) begin
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            mask_l_d    = ch_mask;
                            ptr_d       = lo_new;
                            frame_act_d = 1'b0;
                            if (ch_mask == '0) state_d = StIdle;
                        end else begin
                            ptr_d       = nxt_cur;
                            frame_act_d = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Disabling abandons any partial frame; enabling restarts from a fresh mask.
        if (!enable) begin
            state_d     = StIdle;
            frame_act_d = 1'b0;
        end
        if (en_rise) begin
            mask_l_d    = ch_mask;
            state_d     = StIdle;
            frame_act_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            mask_l_q    <= '0;
            frame_act_q <= 1'b0;
            frame_cnt_q <= '0;
            enable_q    <= 1'b0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mask_l_q    <= mask_l_d;
            frame_act_q <= frame_act_d;
            frame_cnt_q <= frame_cnt_d;
            enable_q    <= enable;
            mode_q      <= mode_eff;
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= q[cand];
                out_ch_q    <= cand;
                out_last_q  <= is_last;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_adc_fifo_arb.sv
// Directed bench for adc_fifo_arb: each FIFO supplies {channel, pop count} samples.
module tb_adc_fifo_arb;

    logic             clk = 1'b0;
    logic             sclr_n;
    logic             enable;
    logic             mode;
    logic [3:0]       ch_mask;
    logic [3:0]       empty;
    logic [3:0][23:0] q;
    logic [3:0]       rdreq;
    logic             out_valid;
    logic             out_ready;
    logic [23:0]      out_data;
    logic [1:0]       out_ch;
    logic             out_last;
    logic [15:0]      frame_cnt;
    logic             busy;

    logic [15:0]      pops [4];
    int               n_tests = 0;
    int               n_fail  = 0;

    adc_fifo_arb #(
        .CHANNELS   (4),
        .DATA_WIDTH (24)
    ) dut (
        .clk       (clk),
        .sclr_n    (sclr_n),
        .enable    (enable),
        .mode      (mode),
        .ch_mask   (ch_mask),
        .empty     (empty),
        .q         (q),
        .rdreq     (rdreq),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // FIFO model: never runs dry unless empty is forced; head is {channel, pops so far}.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!sclr_n) pops[i] <= 16'd0;
            else if (rdreq[i]) pops[i] <= pops[i] + 16'd1;
        end
    end

    always_comb begin
        q = '0;
        for (int i = 0; i < 4; i++) begin
            q[i] = {i[7:0], pops[i]};
        end
    end

    function automatic logic [23:0] smp(input int ch, input int n);
        return {ch[7:0], n[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sclr_n    = 1'b0;
        enable    = 1'b0;
        mode      = 1'b0;
        ch_mask   = 4'b0000;
        empty     = 4'b1111;
        out_ready = 1'b0;
        repeat (3) step();
        sclr_n = 1'b1;
    endtask

    task automatic test_reset();
        sclr_n    = 1'b0;
        enable    = 1'b1;
        mode      = 1'b0;
        ch_mask   = 4'b1111;
        empty     = 4'b0000;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (rdreq !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_rdreq cycle %0d got=%b exp=0000", c, rdreq);
            end
            n_tests++;
            if ({out_valid, out_data, out_ch, out_last, frame_cnt, busy} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d got v=%b d=%h ch=%0d l=%b fc=%h busy=%b exp all 0",
                         c, out_valid, out_data, out_ch, out_last, frame_cnt, busy);
            end
        end
        sclr_n = 1'b1;
        #1;
        n_tests++;
        if (rdreq !== 4'b0000) begin
            n_fail++;
            $display("FAIL latch_cycle_rdreq got=%b exp=0000", rdreq);
        end
        step();
        n_tests++;
        if (rdreq !== 4'b0001) begin
            n_fail++;
            $display("FAIL first_rdreq got=%b exp=0001", rdreq);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== smp(0, 0)) begin
            n_fail++;
            $display("FAIL first_sample got v=%b ch=%0d d=%h exp v=1 ch=0 d=%h",
                     out_valid, out_ch, out_data, smp(0, 0));
        end
    endtask

    task automatic test_round_robin();
        int         seq [6];
        logic [3:0] oh;
        seq = '{0, 1, 3, 0, 1, 3};
        do_reset();
        mode      = 1'b0;
        ch_mask   = 4'b1011;
        empty     = 4'b0000;
        out_ready = 1'b1;
        enable    = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            oh = 4'b0001 << seq[k];
            n_tests++;
            if (rdreq !== oh) begin
                n_fail++;
                $display("FAIL rr_rdreq step %0d got=%b exp=%b", k, rdreq, oh);
            end
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_ch !== 2'(seq[k]) || out_data !== smp(seq[k], k / 3)
                || out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_out step %0d got v=%b ch=%0d d=%h l=%b exp v=1 ch=%0d d=%h l=0",
                         k, out_valid, out_ch, out_data, out_last, seq[k], smp(seq[k], k / 3));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mode      = 1'b0;
        ch_mask   = 4'b1111;
        empty     = 4'b0000;
        out_ready = 1'b1;
        enable    = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++;
            if (rdreq !== 4'b0000 || out_valid !== 1'b1 || out_data !== smp(0, 0)
                || out_ch !== 2'd0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got rdreq=%b v=%b d=%h ch=%0d exp 0000 1 %h 0",
                         c, rdreq, out_valid, out_data, out_ch, smp(0, 0));
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (rdreq !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_resume_rdreq got=%b exp=0010", rdreq);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== smp(1, 0)) begin
            n_fail++;
            $display("FAIL bp_resume_out got v=%b ch=%0d d=%h exp v=1 ch=1 d=%h",
                     out_valid, out_ch, out_data, smp(1, 0));
        end
    endtask

    task automatic test_frame_order();
        do_reset();
        mode      = 1'b1;
        ch_mask   = 4'b0110;
        empty     = 4'b1011;
        out_ready = 1'b1;
        enable    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_tests++;
            if (rdreq !== 4'b0000) begin
                n_fail++;
                $display("FAIL fo_wait cycle %0d got rdreq=%b exp=0000", c, rdreq);
            end
            step();
        end
        empty = 4'b1001;
        #1;
        n_tests++;
        if (rdreq !== 4'b0010) begin
            n_fail++;
            $display("FAIL fo_first_rdreq got=%b exp=0010", rdreq);
        end
        step();
        n_tests++;
        if (out_ch !== 2'd1 || out_last !== 1'b0 || frame_cnt !== 16'd0
            || out_data !== smp(1, 0)) begin
            n_fail++;
            $display("FAIL fo_ch1 got ch=%0d l=%b fc=%0d d=%h exp ch=1 l=0 fc=0 d=%h",
                     out_ch, out_last, frame_cnt, out_data, smp(1, 0));
        end
        n_tests++;
        if (rdreq !== 4'b0100) begin
            n_fail++;
            $display("FAIL fo_second_rdreq got=%b exp=0100", rdreq);
        end
        step();
        n_tests++;
        if (out_ch !== 2'd2 || out_last !== 1'b1 || frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL fo_ch2 got ch=%0d l=%b fc=%0d exp ch=2 l=1 fc=1",
                     out_ch, out_last, frame_cnt);
        end
        empty = 4'b1111;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fo_drain got v=%b busy=%b exp v=0 busy=0", out_valid, busy);
        end
    endtask

    task automatic test_abandon();
        do_reset();
        mode      = 1'b1;
        ch_mask   = 4'b1111;
        empty     = 4'b0000;
        out_ready = 1'b1;
        enable    = 1'b1;
        step();
        step();
        n_tests++;
        if (rdreq !== 4'b0001) begin
            n_fail++;
            $display("FAIL ab_ch0_rdreq got=%b exp=0001", rdreq);
        end
        step();
        step();
        n_tests++;
        if (out_ch !== 2'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ab_ch1 got ch=%0d busy=%b exp ch=1 busy=1", out_ch, busy);
        end
        enable = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_tests++;
            if (rdreq !== 4'b0000) begin
                n_fail++;
                $display("FAIL ab_disabled cycle %0d got rdreq=%b exp=0000", c, rdreq);
            end
            step();
        end
        enable = 1'b1;
        step();
        step();
        n_tests++;
        if (rdreq !== 4'b0001) begin
            n_fail++;
            $display("FAIL ab_restart_rdreq got=%b exp=0001", rdreq);
        end
        step();
        n_tests++;
        if (out_ch !== 2'd0 || frame_cnt !== 16'd0 || out_data !== smp(0, 1)) begin
            n_fail++;
            $display("FAIL ab_restart got ch=%0d fc=%0d d=%h exp ch=0 fc=0 d=%h",
                     out_ch, frame_cnt, out_data, smp(0, 1));
        end
    endtask

    task automatic test_wrap_and_mask();
        do_reset();
        mode      = 1'b1;
        ch_mask   = 4'b0001;
        empty     = 4'b0000;
        out_ready = 1'b1;
        enable    = 1'b1;
        step();
        step();
        repeat (65535) step();
        n_tests++;
        if (frame_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preload got fc=%h exp=ffff", frame_cnt);
        end
        ch_mask = 4'b0011;
        step();
        n_tests++;
        if (frame_cnt !== 16'h0000 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_zero got fc=%h l=%b exp fc=0000 l=1", frame_cnt, out_last);
        end
        n_tests++;
        if (rdreq !== 4'b0001) begin
            n_fail++;
            $display("FAIL mask_f1_ch0_rdreq got=%b exp=0001", rdreq);
        end
        ch_mask = 4'b0100;
        step();
        n_tests++;
        if (out_ch !== 2'd0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_f1_ch0 got ch=%0d l=%b exp ch=0 l=0", out_ch, out_last);
        end
        n_tests++;
        if (rdreq !== 4'b0010) begin
            n_fail++;
            $display("FAIL mask_f1_ch1_rdreq got=%b exp=0010", rdreq);
        end
        step();
        n_tests++;
        if (out_ch !== 2'd1 || out_last !== 1'b1 || frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL mask_f1_ch1 got ch=%0d l=%b fc=%0d exp ch=1 l=1 fc=1",
                     out_ch, out_last, frame_cnt);
        end
        n_tests++;
        if (rdreq !== 4'b0100) begin
            n_fail++;
            $display("FAIL mask_f2_rdreq got=%b exp=0100", rdreq);
        end
        step();
        n_tests++;
        if (out_ch !== 2'd2 || out_last !== 1'b1 || frame_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL mask_f2_ch2 got ch=%0d l=%b fc=%0d exp ch=2 l=1 fc=2",
                     out_ch, out_last, frame_cnt);
        end
    endtask

    initial begin
        sclr_n    = 1'b0;
        enable    = 1'b0;
        mode      = 1'b0;
        ch_mask   = 4'b0000;
        empty     = 4'b1111;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_frame_order();
        test_abandon();
        test_wrap_and_mask();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
